lpif_link_online_seq: RTL and testbench

Link bring-up sequencer for the LPIF x16 asym2 slave. It drives the `tx_online` and `rx_online` controls of the slave top and watches the delayed online feedback from auto-sync. It brings the link up in order, enforces per-step timeouts, takes the link down on PHY or link faults, and either retries after a backoff or latches a sticky error. It sits between the link-management software registers and the slave top, in the `clk_wr` domain.

---
 rtl/lpif_link_online_seq.sv | 167 ++++++++++++++++
 tb/tb_lpif_link_online_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/lpif_link_online_seq.sv
// Link bring-up sequencer for the LPIF x16 asym2 slave: drives tx/rx online, checks auto-sync feedback,
// applies step timeouts and fault handling. Optional retry/backoff: define LPIF_LINK_SEQ_RETRY_EN.
//
// state    | meaning
// IDLE     | link down, retry count and fault cause cleared
// WAIT_PHY | waiting for phy_ready
// TX_ON    | tx_online driven, waiting for tx feedback
// RX_ON    | tx and rx online driven, waiting for rx feedback
// ACTIVE   | link up, monitoring phy and feedback
// BACKOFF  | idle delay after a fault before the next attempt
// ERROR    | sticky failure, exits only when link_en drops
module lpif_link_online_seq #(
  parameter int unsigned TIMER_WIDTH    = 16,
  parameter int unsigned BACKOFF_CYCLES = 32,
  parameter int unsigned MAX_RETRY      = 3,
  localparam int unsigned RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1)
) (
  input  logic                   clk_wr,
  input  logic                   rst_wr_n,
  input  logic                   link_en,
  input  logic                   phy_ready,
  input  logic                   tx_online_delay_i,
  input  logic                   rx_online_delay_i,
  input  logic [TIMER_WIDTH-1:0] timeout_value,
  output logic                   tx_online,
  output logic                   rx_online,
  output logic                   link_up,
  output logic                   link_err,
  output logic [2:0]             seq_state,
  output logic [RW-1:0]          retry_cnt,
  output logic [1:0]             fault_cause
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_PHY = 3'd1,
    S_TX_ON    = 3'd2,
    S_RX_ON    = 3'd3,
    S_ACTIVE   = 3'd4,
    S_BACKOFF  = 3'd5,
    S_ERROR    = 3'd6
  } state_t;

  localparam logic [TIMER_WIDTH-1:0] BACKOFF_LAST = TIMER_WIDTH'(BACKOFF_CYCLES - 1);

  state_t                 state, state_nxt;
  logic [TIMER_WIDTH-1:0] timer, timer_nxt;
  logic [1:0]             cause_q, cause_nxt;
  logic                   fault;
  logic [1:0]             fault_code;
  logic                   timeout_hit;

`ifdef LPIF_LINK_SEQ_RETRY_EN
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
  logic [RW-1:0] retry_q, retry_nxt;
`endif

  assign timeout_hit = (timeout_value != '0) && (timer == timeout_value);

  always_comb begin
    state_nxt  = state;
    cause_nxt  = cause_q;
    fault      = 1'b0;
    fault_code = 2'd0;
`ifdef LPIF_LINK_SEQ_RETRY_EN
    retry_nxt  = retry_q;
`endif
    if (state == S_IDLE) begin
      cause_nxt = 2'd0;
`ifdef LPIF_LINK_SEQ_RETRY_EN
      retry_nxt = '0;
`endif
    end

    if (!link_en && state != S_ERROR) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:     state_nxt = S_WAIT_PHY;
        S_WAIT_PHY: if (phy_ready) state_nxt = S_TX_ON;
        S_TX_ON: begin
          if (!phy_ready) begin
            fault = 1'b1; fault_code = 2'd2;
          end else if (tx_online_delay_i) begin
            state_nxt = S_RX_ON;
          end else if (timeout_hit) begin
            fault = 1'b1; fault_code = 2'd1;
          end
        end
        S_RX_ON: begin
          if (!phy_ready) begin
            fault = 1'b1; fault_code = 2'd2;
          end else if (!tx_online_delay_i) begin
            fault = 1'b1; fault_code = 2'd3;
          end else if (rx_online_delay_i) begin
            state_nxt = S_ACTIVE;
          end else if (timeout_hit) begin
            fault = 1'b1; fault_code = 2'd1;
          end
        end
        S_ACTIVE: begin
          if (!phy_ready) begin
            fault = 1'b1; fault_code = 2'd2;
          end else if (!tx_online_delay_i || !rx_online_delay_i) begin
            fault = 1'b1; fault_code = 2'd3;
          end
        end
        S_BACKOFF: if (timer == BACKOFF_LAST) state_nxt = S_WAIT_PHY;
        S_ERROR:   if (!link_en) state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end

    if (fault) begin
      cause_nxt = fault_code;
`ifdef LPIF_LINK_SEQ_RETRY_EN
      if (retry_q < RETRY_LIMIT) begin
        retry_nxt = retry_q + RW'(1);
        state_nxt = S_BACKOFF;
      end else begin
        state_nxt = S_ERROR;
      end
`else
      state_nxt = S_ERROR;
`endif
    end

    // Any state change restarts the timer, so every timed step starts from 0.
    timer_nxt = '0;
    if (state_nxt == state &&
        (state == S_TX_ON || state == S_RX_ON || state == S_BACKOFF)) begin
      timer_nxt = (timer != '1) ? timer + TIMER_WIDTH'(1) : timer;
    end
  end

  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      state   <= S_IDLE;
      timer   <= '0;
      cause_q <= 2'd0;
`ifdef LPIF_LINK_SEQ_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      cause_q <= cause_nxt;
`ifdef LPIF_LINK_SEQ_RETRY_EN
      retry_q <= retry_nxt;
`endif
    end
  end

`ifdef LPIF_LINK_SEQ_RETRY_EN
  assign retry_cnt = retry_q;
`else
  assign retry_cnt = '0;
`endif

  assign tx_online   = (state == S_TX_ON) || (state == S_RX_ON) || (state == S_ACTIVE);
  assign rx_online   = (state == S_RX_ON) || (state == S_ACTIVE);
  assign link_up     = (state == S_ACTIVE);
  assign link_err    = (state == S_ERROR);
  assign seq_state   = state;
  assign fault_cause = cause_q;

endmodule

// File: tb/tb_lpif_link_online_seq.sv
// Scoreboard bench for lpif_link_online_seq: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_lpif_link_online_seq;
  localparam int TW = 16;

  logic          clk_wr = 1'b0;
  logic          rst_wr_n = 1'b0;
  logic          link_en = 1'b0;
  logic          phy_ready = 1'b0;
  logic          auto_fb = 1'b0;
  logic          tx_man = 1'b0, rx_man = 1'b0;
  logic          tx_q = 1'b0, rx_q = 1'b0;
  logic          tx_online_delay_i, rx_online_delay_i;
  logic [TW-1:0] timeout_value = '0;
  logic          tx_online, rx_online, link_up, link_err;
  logic [2:0]    seq_state;
  logic [1:0]    retry_cnt;
  logic [1:0]    fault_cause;

  always #5 clk_wr = ~clk_wr;

  lpif_link_online_seq #(.TIMER_WIDTH(TW), .BACKOFF_CYCLES(32), .MAX_RETRY(3)) dut (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .link_en(link_en), .phy_ready(phy_ready),
    .tx_online_delay_i(tx_online_delay_i), .rx_online_delay_i(rx_online_delay_i),
    .timeout_value(timeout_value), .tx_online(tx_online), .rx_online(rx_online),
    .link_up(link_up), .link_err(link_err), .seq_state(seq_state),
    .retry_cnt(retry_cnt), .fault_cause(fault_cause));

  // Auto-sync model: feedback follows the online outputs one cycle later.
  always @(posedge clk_wr) begin
    tx_q <= tx_online;
    rx_q <= rx_online;
  end
  assign tx_online_delay_i = auto_fb ? tx_q : tx_man;
  assign rx_online_delay_i = auto_fb ? rx_q : rx_man;

  typedef struct {
    int    cyc;
    string name;
    int    st;
    int    rc;
    int    fc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;

  always @(posedge clk_wr) cyc <= cyc + 1;

  task automatic expect_at(input int dly, input string nm, input int st, input int rc, input int fc);
    exp_t e;
    e.cyc = cyc + dly; e.name = nm; e.st = st; e.rc = rc; e.fc = fc;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_wr);
      #1;
    end
  endtask

  // rc/fc of -1 mean the field is not checked for that entry.
  always @(negedge clk_wr) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic et, er, eu, ee, bad;
      e  = sb.pop_front();
      et = (e.st == 2 || e.st == 3 || e.st == 4);
      er = (e.st == 3 || e.st == 4);
      eu = (e.st == 4);
      ee = (e.st == 6);
      bad = (e.cyc != cyc) || (int'(seq_state) != e.st) || (tx_online !== et) ||
            (rx_online !== er) || (link_up !== eu) || (link_err !== ee) ||
            (e.rc >= 0 && int'(retry_cnt) != e.rc) || (e.fc >= 0 && int'(fault_cause) != e.fc);
      n_run++;
      if (bad) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got state=%0d tx=%b rx=%b up=%b err=%b rc=%0d fc=%0d; need state=%0d tx=%b rx=%b up=%b err=%b rc=%0d fc=%0d (due cyc %0d)",
                 e.name, cyc, seq_state, tx_online, rx_online, link_up, link_err, retry_cnt, fault_cause,
                 e.st, et, er, eu, ee, e.rc, e.fc, e.cyc);
      end
    end
  end

  initial begin
    // Reset
    expect_at(1, "reset", 0, 0, 0);
    step(1);
    rst_wr_n = 1'b1;
    expect_at(1, "idle_hold", 0, 0, 0);
    step(1);

    // Clean bring-up with one-cycle feedback: ACTIVE at edge 6
    auto_fb = 1'b1; link_en = 1'b1; phy_ready = 1'b1;
    expect_at(1, "up_wait_phy", 1, 0, 0);
    expect_at(2, "up_tx_on", 2, 0, 0);
    expect_at(3, "up_tx_wait", 2, 0, 0);
    expect_at(4, "up_rx_on", 3, 0, 0);
    expect_at(5, "up_rx_wait", 3, 0, 0);
    expect_at(6, "up_active", 4, 0, 0);
    step(6);

    // link_en drop beats simultaneous rx feedback drop
    auto_fb = 1'b0; tx_man = 1'b1; rx_man = 1'b0; link_en = 1'b0;
    expect_at(1, "simul_idle", 0, 0, 0);
    expect_at(2, "simul_idle2", 0, 0, 0);
    step(2);

    // Immediate feedback bring-up, then a one-cycle phy_ready drop in ACTIVE
    rx_man = 1'b1; link_en = 1'b1; phy_ready = 1'b1;
    expect_at(1, "imm_wait_phy", 1, 0, 0);
    expect_at(2, "imm_tx_on", 2, 0, 0);
    expect_at(3, "imm_rx_on", 3, 0, 0);
    expect_at(4, "imm_active", 4, 0, 0);
    step(4);
    phy_ready = 1'b0;
`ifdef LPIF_LINK_SEQ_RETRY_EN
    expect_at(1, "phy_drop", 5, 1, 2);
    step(1);
    phy_ready = 1'b1;
    expect_at(31, "backoff_last", 5, 1, 2);
    expect_at(32, "backoff_exit", 1, 1, 2);
    expect_at(35, "retry_active", 4, 1, 2);
    step(35);
`else
    expect_at(1, "phy_drop", 6, 0, 2);
    step(1);
    phy_ready = 1'b1;
    expect_at(3, "phy_err_hold", 6, 0, 2);
    step(3);
`endif
    link_en = 1'b0;
    expect_at(2, "idle_clear", 0, 0, 0);
    step(2);

    // TX timeout with no tx feedback
    tx_man = 1'b0; rx_man = 1'b0; link_en = 1'b1;
`ifdef LPIF_LINK_SEQ_RETRY_EN
    timeout_value = 16'd10;
    expect_at(1, "to_wait_phy", 1, 0, 0);
    expect_at(2, "to_tx_first", 2, 0, 0);
    expect_at(12, "to_tx_last", 2, 0, 0);
    expect_at(13, "to_fault1", 5, 1, 1);
    expect_at(44, "to_backoff_last", 5, 1, 1);
    expect_at(45, "to_backoff_exit", 1, 1, 1);
    expect_at(46, "to_tx_retry", 2, 1, 1);
    expect_at(57, "to_fault2", 5, 2, 1);
    expect_at(101, "to_fault3", 5, 3, 1);
    expect_at(145, "to_error", 6, 3, 1);
    expect_at(150, "to_error_hold", 6, 3, 1);
    step(150);
`else
    timeout_value = 16'd4;
    expect_at(1, "to_wait_phy", 1, 0, 0);
    expect_at(2, "to_tx_first", 2, 0, 0);
    expect_at(6, "to_tx_last", 2, 0, 0);
    expect_at(7, "to_error", 6, 0, 1);
    expect_at(10, "to_error_hold", 6, 0, 1);
    step(10);
`endif
    link_en = 1'b0;
    expect_at(1, "err_exit", 0, -1, -1);
    expect_at(2, "err_exit_clear", 0, 0, 0);
    step(2);

    // Timeout disabled, then reset while in RX_ON
    timeout_value = '0; tx_man = 1'b1; rx_man = 1'b0; link_en = 1'b1;
    expect_at(1, "rst_wait_phy", 1, 0, 0);
    expect_at(2, "rst_tx_on", 2, 0, 0);
    expect_at(3, "rst_rx_on", 3, 0, 0);
    expect_at(23, "no_timeout", 3, 0, 0);
    step(23);
    rst_wr_n = 1'b0;
    expect_at(1, "mid_reset", 0, 0, 0);
    step(1);
    rst_wr_n = 1'b1;
    expect_at(1, "post_reset", 1, 0, 0);
    expect_at(2, "c3_tx_on", 2, 0, 0);
    expect_at(3, "c3_rx_on", 3, 0, 0);
    step(3);

    // tx feedback lost in RX_ON
    tx_man = 1'b0;
`ifdef LPIF_LINK_SEQ_RETRY_EN
    expect_at(1, "fb_drop", 5, 1, 3);
`else
    expect_at(1, "fb_drop", 6, 0, 3);
`endif
    step(1);
    link_en = 1'b0;
    step(1);

    for (int i = 0; i < 5 && sb.size() > 0; i++) step(1);
    if (sb.size() > 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, need 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
